// File: rtl/alu_result_stage_if.sv
// Handshake and payload bundle between the ALU units, the result stage and its consumer.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] res_and;
    logic [WIDTH-1:0] res_or;
    logic [WIDTH-1:0] res_nor;
    logic [WIDTH-1:0] res_add;
    logic [WIDTH-1:0] res_sub;
    logic             cout_add;
    logic             cout_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out1;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
    logic             op_err;

    // Producer/consumer side: drives operations and out_ready, observes results.
    modport master (
        output in_valid, op, in1, in2,
        output res_and, res_or, res_nor, res_add, res_sub,
        output cout_add, cout_sub, out_ready,
        input  in_ready, out_valid, out1, zero, neg, carry, ovf, op_err
    );

    // Result stage side.
    modport slave (
        input  in_valid, op, in1, in2,
        input  res_and, res_or, res_nor, res_add, res_sub,
        input  cout_add, cout_sub, out_ready,
        output in_ready, out_valid, out1, zero, neg, carry, ovf, op_err
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result select + Z/N/C/V flag generation feeding a 2-entry skid buffer.
module alu_result_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_stage_if.slave  bus
);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    logic   valid_q;
    logic   rdy_q;
    logic   err_q;

    entry_t nxt;
    logic   illegal;
    logic   v_add;
    logic   v_sub;
    logic   ready_gated;
    logic   accept;
    logic   drain;

    // in_ready comes from the state register; held low while reset is asserted.
    assign ready_gated = rdy_q & rst_n;
    assign accept      = bus.in_valid & ready_gated;
    assign drain       = valid_q & bus.out_ready;

    // Select the unit result for this op and derive its flags.
    always_comb begin
        nxt     = '0;
        illegal = 1'b0;
        v_add   = (bus.in1[MSB] == bus.in2[MSB]) & (bus.res_add[MSB] != bus.in1[MSB]);
        v_sub   = (bus.in1[MSB] != bus.in2[MSB]) & (bus.res_sub[MSB] != bus.in1[MSB]);
        case (bus.op)
            OP_AND:  nxt.res = bus.res_and;
            OP_OR:   nxt.res = bus.res_or;
            OP_NOR:  nxt.res = bus.res_nor;
            OP_ADD: begin
                nxt.res   = bus.res_add;
                nxt.carry = bus.cout_add;
                nxt.ovf   = v_add;
            end
            OP_SUB: begin
                nxt.res   = bus.res_sub;
                nxt.carry = bus.cout_sub;
                nxt.ovf   = v_sub;
            end
            // Signed less-than: sign of the difference corrected by overflow.
            OP_SLT:  nxt.res = {{(WIDTH-1){1'b0}}, bus.res_sub[MSB] ^ v_sub};
            OP_PASS: nxt.res = bus.in1;
            default: begin
                nxt.res = '0;
                illegal = 1'b1;
            end
        endcase
        nxt.zero = (nxt.res == '0);
        nxt.neg  = nxt.res[MSB];
    end

    // Skid-buffer FSM: main drives the outputs, skid absorbs one entry while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            if (accept && illegal) begin
                err_q <= 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= nxt;
                        valid_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_q <= nxt;
                    end else if (accept) begin
                        skid_q <= nxt;
                        rdy_q  <= 1'b0;
                        state  <= FULL;
                    end else if (drain) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_q <= skid_q;
                        rdy_q  <= 1'b1;
                        state  <= ONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    rdy_q   <= 1'b1;
                    state   <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready_gated;
    assign bus.out_valid = valid_q;
    assign bus.out1      = main_q.res;
    assign bus.zero      = main_q.zero;
    assign bus.neg       = main_q.neg;
    assign bus.carry     = main_q.carry;
    assign bus.ovf       = main_q.ovf;
    assign bus.op_err    = err_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flags, streaming, skid stall, illegal op, reset.
module tb_alu_result_stage;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_result_stage_if #(.WIDTH(32)) bus ();

    alu_result_stage #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present an operation; the unit results are what the upstream units would produce.
    task automatic set_in(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum           = {1'b0, a} + {1'b0, b};
        bus.op        = op;
        bus.in1       = a;
        bus.in2       = b;
        bus.res_and   = a & b;
        bus.res_or    = a | b;
        bus.res_nor   = ~(a | b);
        bus.res_add   = sum[31:0];
        bus.cout_add  = sum[32];
        bus.res_sub   = a - b;
        bus.cout_sub  = (a >= b);
        bus.in_valid  = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic [31:0] o,
                             input logic z, input logic n, input logic c, input logic v);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".out1"},  bus.out1, o);
        chk({tag, ".zero"},  32'(bus.zero),  32'(z));
        chk({tag, ".neg"},   32'(bus.neg),   32'(n));
        chk({tag, ".carry"}, 32'(bus.carry), 32'(c));
        chk({tag, ".ovf"},   32'(bus.ovf),   32'(v));
    endtask

    logic [2:0]  s_op  [8];
    logic [31:0] s_a   [8];
    logic [31:0] s_b   [8];
    logic [31:0] s_exp [8];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        set_in(3'b000, 32'h0, 32'h0);
        bus.in_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.out1",  bus.out1, 32'h0);
        chk("rst.ready", 32'(bus.in_ready), 32'd0);
        chk("rst.err",   32'(bus.op_err), 32'd0);
        chk("rst.flags", {28'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.ready", 32'(bus.in_ready), 32'd1);

        // Single ops, one-cycle latency, drained on the following accept
        set_in(3'b011, 32'h7FFFFFFF, 32'h1);
        tick(); bus.in_valid = 1'b0;
        chk_flags("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        set_in(3'b100, 32'd5, 32'd5);
        tick(); bus.in_valid = 1'b0;
        chk_flags("sub_eq", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        set_in(3'b101, 32'hFFFFFFFD, 32'd2);
        tick(); bus.in_valid = 1'b0;
        chk_flags("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(3'b101, 32'h80000000, 32'd1);
        tick(); bus.in_valid = 1'b0;
        chk_flags("slt_ovf", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(3'b101, 32'd5, 32'd3);
        tick(); bus.in_valid = 1'b0;
        chk_flags("slt_ge", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(3'b100, 32'h80000000, 32'd1);
        tick(); bus.in_valid = 1'b0;
        chk_flags("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        set_in(3'b011, 32'hFFFFFFFF, 32'd1);
        tick(); bus.in_valid = 1'b0;
        chk_flags("add_cy", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        set_in(3'b110, 32'hDEADBEEF, 32'd7);
        tick(); bus.in_valid = 1'b0;
        chk_flags("pass", 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("drain.valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back streaming of 8 bitwise ops
        s_op[0] = 3'b000; s_a[0] = 32'hF0F0F0F0; s_b[0] = 32'hFF00FF00; s_exp[0] = 32'hF000F000;
        s_op[1] = 3'b001; s_a[1] = 32'hF0F0F0F0; s_b[1] = 32'hFF00FF00; s_exp[1] = 32'hFFF0FFF0;
        s_op[2] = 3'b010; s_a[2] = 32'hF0F0F0F0; s_b[2] = 32'hFF00FF00; s_exp[2] = 32'h000F000F;
        s_op[3] = 3'b000; s_a[3] = 32'h12345678; s_b[3] = 32'h0F0F0F0F; s_exp[3] = 32'h02040608;
        s_op[4] = 3'b001; s_a[4] = 32'h12345678; s_b[4] = 32'h0F0F0F0F; s_exp[4] = 32'h1F3F5F7F;
        s_op[5] = 3'b010; s_a[5] = 32'h12345678; s_b[5] = 32'h0F0F0F0F; s_exp[5] = 32'hE0C0A080;
        s_op[6] = 3'b010; s_a[6] = 32'h0;        s_b[6] = 32'h0;        s_exp[6] = 32'hFFFFFFFF;
        s_op[7] = 3'b000; s_a[7] = 32'h0;        s_b[7] = 32'h0;        s_exp[7] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            set_in(s_op[i], s_a[i], s_b[i]);
            tick();
            chk($sformatf("stream%0d.out1", i), bus.out1, s_exp[i]);
            chk($sformatf("stream%0d.valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stream%0d.ready", i), 32'(bus.in_ready), 32'd1);
        end
        chk("stream7.zero", 32'(bus.zero), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("stream.empty", 32'(bus.out_valid), 32'd0);

        // Stall: two accepts fill main+skid, a third held op waits
        bus.out_ready = 1'b0;
        set_in(3'b011, 32'd1, 32'd2);
        tick();
        chk("stall1.ready", 32'(bus.in_ready), 32'd1);
        chk("stall1.out1", bus.out1, 32'd3);
        set_in(3'b100, 32'd10, 32'd3);
        tick();
        chk("stall2.ready", 32'(bus.in_ready), 32'd0);
        chk("stall2.out1", bus.out1, 32'd3);
        set_in(3'b000, 32'hFF, 32'h0F);
        tick();
        chk("stall3.ready", 32'(bus.in_ready), 32'd0);
        chk("stall3.out1", bus.out1, 32'd3);
        bus.out_ready = 1'b1;
        tick();
        chk("skid.out1", bus.out1, 32'd7);
        chk("skid.ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("held.out1", bus.out1, 32'h0F);
        chk("held.valid", 32'(bus.out_valid), 32'd1);
        tick();
        chk("stall.empty", 32'(bus.out_valid), 32'd0);

        // Illegal op is sticky until reset
        set_in(3'b111, 32'd5, 32'd5);
        tick(); bus.in_valid = 1'b0;
        chk_flags("illegal", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("illegal.err", 32'(bus.op_err), 32'd1);
        set_in(3'b001, 32'd1, 32'd2);
        tick(); bus.in_valid = 1'b0;
        chk("legal.out1", bus.out1, 32'd3);
        chk("legal.err", 32'(bus.op_err), 32'd1);
        tick();

        // Reset while FULL discards both entries
        bus.out_ready = 1'b0;
        set_in(3'b011, 32'd1, 32'd1);
        tick();
        set_in(3'b011, 32'd2, 32'd2);
        tick();
        bus.in_valid = 1'b0;
        chk("full.ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstfull.ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        chk("rstfull.valid", 32'(bus.out_valid), 32'd0);
        chk("rstfull.out1", bus.out1, 32'h0);
        chk("rstfull.err", 32'(bus.op_err), 32'd0);
        chk("rstfull.ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("relfull.ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("relfull.valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("relfull.valid2", 32'(bus.out_valid), 32'd0);
        chk("relfull.out1", bus.out1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a runaway simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
